quot_bcd_formatter: RTL

Downstream consumer of the unsigned Q6.4 fixed-point divider. It captures the divider's quotient and its dvz/ovf flags when valid pulses, then converts the value to packed BCD over several cycles: 2 integer digits and 4 exact fractional digits. The BCD result drives the display/report stage. The block is a multi-cycle FSM with a busy/done handshake that matches the divider's style.

---
 rtl/quot_bcd_formatter_pkg.sv | 38 +++
 rtl/quot_bcd_formatter_if.sv | 30 +++
 rtl/quot_bcd_formatter_bcd_add3.sv | 10 +
 rtl/quot_bcd_formatter.sv | 119 +++++++++++
 4 files changed

// File: rtl/quot_bcd_formatter_pkg.sv
// Shared constants and types for the quotient BCD formatter.
// Fixed-point format, digit counts, FSM states and step counters.
package quot_fmt_pkg;

  localparam int INT_W       = 6;
  localparam int FRAC_W      = 4;
  localparam int Q_W         = INT_W + FRAC_W;
  localparam int INT_DIGITS  = 2;
  localparam int FRAC_DIGITS = 4;

  localparam int INT_BCD_W  = 4 * INT_DIGITS;
  localparam int FRAC_BCD_W = 4 * FRAC_DIGITS;

  localparam logic [3:0] ERR_DIGIT = 4'hF;

  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] INT_LAST =
    CNT_W'(INT_W - 1);
  localparam logic [CNT_W-1:0] FRAC_LAST =
    CNT_W'(FRAC_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INT  = 2'd1,
    FRAC = 2'd2
  } state_t;

  // Multiply a fraction by ten with shifts; the high nibble
  // is the next decimal digit, the low bits the remainder.
  function automatic logic [FRAC_W+3:0] mul10(
    input logic [FRAC_W-1:0] f
  );
    logic [FRAC_W+3:0] w;
    w = {4'b0000, f};
    return (w << 3) + (w << 1);
  endfunction

endpackage

// File: rtl/quot_bcd_formatter_if.sv
// Handshake bundle between the divider and the BCD formatter.
// master drives the quotient, slave is the formatter.
interface quot_bcd_formatter_if;
  import quot_fmt_pkg::*;

  logic [Q_W-1:0]        q_in;
  logic                  dvz_in;
  logic                  ovf_in;
  logic                  valid_in;
  logic                  busy;
  logic [INT_BCD_W-1:0]  int_bcd;
  logic [FRAC_BCD_W-1:0] frac_bcd;
  logic                  dvz_out;
  logic                  ovf_out;
  logic                  done;
  logic                  overrun;

  modport master (
    output q_in, dvz_in, ovf_in, valid_in,
    input  busy, int_bcd, frac_bcd,
    input  dvz_out, ovf_out, done, overrun
  );

  modport slave (
    input  q_in, dvz_in, ovf_in, valid_in,
    output busy, int_bcd, frac_bcd,
    output dvz_out, ovf_out, done, overrun
  );

endinterface

// File: rtl/quot_bcd_formatter_bcd_add3.sv
// Double-dabble digit corrector.
// Adds 3 to a BCD digit of 5 or more before the shift.
module bcd_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/quot_bcd_formatter.sv
// Converts a Q6.4 divider quotient into packed BCD.
// Integer by double-dabble, fraction by repeated x10.
module quot_bcd_formatter
  import quot_fmt_pkg::*;
(
  input logic clk,
  input logic sclr_n,
  quot_bcd_formatter_if.slave bus
);

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [INT_W-1:0]        int_sh;
  logic [FRAC_W-1:0]       frac_r;
  logic [INT_BCD_W-1:0]    bcd_i;
  logic [FRAC_BCD_W-5:0]   bcd_f;
  logic [INT_BCD_W-1:0]    adj;
  logic [FRAC_W+3:0]       t;
  logic [3:0]              digit;

  logic                    busy_r;
  logic                    done_r;
  logic                    ovr_r;
  logic                    dvz_r;
  logic                    ovf_r;
  logic [INT_BCD_W-1:0]    int_r;
  logic [FRAC_BCD_W-1:0]   frac_o;

  for (genvar g = 0; g < INT_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .d (bcd_i[4*g+3:4*g]),
      .q (adj[4*g+3:4*g])
    );
  end

  assign t     = mul10(frac_r);
  assign digit = t[FRAC_W+3:FRAC_W];

  // Capture, convert and publish; all outputs registered.
  always_ff @(posedge clk) begin
    if (!sclr_n) begin
      state  <= IDLE;
      cnt    <= '0;
      int_sh <= '0;
      frac_r <= '0;
      bcd_i  <= '0;
      bcd_f  <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      ovr_r  <= 1'b0;
      dvz_r  <= 1'b0;
      ovf_r  <= 1'b0;
      int_r  <= '0;
      frac_o <= '0;
    end else begin
      done_r <= 1'b0;
      ovr_r  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.valid_in) begin
            if (bus.dvz_in || bus.ovf_in) begin
              int_r  <= {INT_DIGITS{ERR_DIGIT}};
              frac_o <= {FRAC_DIGITS{ERR_DIGIT}};
              dvz_r  <= bus.dvz_in;
              ovf_r  <= bus.ovf_in;
              done_r <= 1'b1;
            end else begin
              int_sh <= bus.q_in[Q_W-1:FRAC_W];
              frac_r <= bus.q_in[FRAC_W-1:0];
              bcd_i  <= '0;
              bcd_f  <= '0;
              cnt    <= '0;
              busy_r <= 1'b1;
              state  <= INT;
            end
          end
        end
        INT: begin
          if (bus.valid_in) ovr_r <= 1'b1;
          bcd_i  <= {adj[INT_BCD_W-2:0], int_sh[INT_W-1]};
          int_sh <= {int_sh[INT_W-2:0], 1'b0};
          if (cnt == INT_LAST) begin
            cnt   <= '0;
            state <= FRAC;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FRAC: begin
          if (bus.valid_in) ovr_r <= 1'b1;
          frac_r <= t[FRAC_W-1:0];
          bcd_f  <= {bcd_f[FRAC_BCD_W-9:0], digit};
          if (cnt == FRAC_LAST) begin
            cnt    <= '0;
            int_r  <= bcd_i;
            frac_o <= {bcd_f, digit};
            dvz_r  <= 1'b0;
            ovf_r  <= 1'b0;
            done_r <= 1'b1;
            busy_r <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.overrun  = ovr_r;
  assign bus.dvz_out  = dvz_r;
  assign bus.ovf_out  = ovf_r;
  assign bus.int_bcd  = int_r;
  assign bus.frac_bcd = frac_o;

endmodule
